// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, image sizes and the line/frame region type.
package vga_pkg;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;
   localparam int DEF_ORIG_SIZE = 400;
   localparam int DEF_ZOOM_SIZE = 300;

   localparam int CNT_W  = 10;
   localparam int ADDR_W = 18;

   typedef enum logic [1:0] {
      VISIBLE,
      FRONT,
      SYNC,
      BACK
   } region_e;

   function automatic region_e region_of(
      input logic [CNT_W-1:0] c,
      input int               vis,
      input int               fp,
      input int               syn
   );
      int ci;
      ci = int'(c);
      if (ci < vis)
         return VISIBLE;
      else if (ci < vis + fp)
         return FRONT;
      else if (ci < vis + fp + syn)
         return SYNC;
      else
         return BACK;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick h/v counters, region decode and frame-start strobe.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic [CNT_W-1:0] h_nxt,
   output logic [CNT_W-1:0] v_nxt,
   output region_e          h_region,
   output region_e          v_region,
   output logic             frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   always_comb begin
      h_nxt = h_cnt + 1'b1;
      v_nxt = v_cnt;
      if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
         h_nxt = '0;
         if (v_cnt == CNT_W'(V_TOTAL - 1))
            v_nxt = '0;
         else
            v_nxt = v_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
      end
   end

   assign h_region = region_of(h_cnt, H_VISIBLE, H_FP, H_SYNC);
   assign v_region = region_of(v_cnt, V_VISIBLE, V_FP, V_SYNC);

   // The tick spent at (0,0) is the first tick of a frame, including after reset.
   assign frame_start = pix_en & ~reset & (h_cnt == '0) & (v_cnt == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// Streams a square grayscale image from VRAM into a VGA raster.
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter int ORIG_SIZE = DEF_ORIG_SIZE,
   parameter int ZOOM_SIZE = DEF_ZOOM_SIZE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic        image_select,
   input  logic [7:0]  vram_out,
   output logic [31:0] gpu_address,
   output logic        image_select_out,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [7:0]  pixel,
   output logic        frame_start
);

   logic [CNT_W-1:0]  h_cnt, v_cnt, h_nxt, v_nxt;
   region_e           h_region, v_region;
   logic [ADDR_W-1:0] addr;
   logic              sel_nxt;
   logic [CNT_W-1:0]  w_cur, w_nxt;
   logic              in_cur, in_nxt;

   vga_timing #(
      .H_VISIBLE (H_VISIBLE),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_VISIBLE (V_VISIBLE),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP)
   ) u_timing (
      .clk         (clk),
      .reset       (reset),
      .pix_en      (pix_en),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .h_nxt       (h_nxt),
      .v_nxt       (v_nxt),
      .h_region    (h_region),
      .v_region    (v_region),
      .frame_start (frame_start)
   );

   // The select being latched this tick governs the position we move to.
   assign sel_nxt = frame_start ? image_select : image_select_out;
   assign w_cur   = image_select_out ? CNT_W'(ZOOM_SIZE) : CNT_W'(ORIG_SIZE);
   assign w_nxt   = sel_nxt ? CNT_W'(ZOOM_SIZE) : CNT_W'(ORIG_SIZE);
   assign in_cur  = (h_cnt < w_cur) && (v_cnt < w_cur);
   assign in_nxt  = (h_nxt < w_nxt) && (v_nxt < w_nxt);

   always_ff @(posedge clk) begin
      if (reset) begin
         addr             <= '0;
         image_select_out <= 1'b0;
         hsync            <= 1'b1;
         vsync            <= 1'b1;
         de               <= 1'b0;
         pixel            <= '0;
      end else if (pix_en) begin
         image_select_out <= sel_nxt;
         if (h_nxt == '0 && v_nxt == '0)
            addr <= '0;
         else if (in_nxt)
            addr <= addr + 1'b1;
         hsync <= (h_region != SYNC);
         vsync <= (v_region != SYNC);
         de    <= (h_region == VISIBLE) && (v_region == VISIBLE);
         pixel <= in_cur ? vram_out : 8'd0;
      end
   end

   assign gpu_address = {{(32 - ADDR_W){1'b0}}, addr};

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench on a scaled raster: 60 ticks/line, 38 lines, images 20/15.
module tb_vga_frame_reader;

   localparam int HV = 40, HF = 4, HS = 8, HB = 8;
   localparam int VV = 30, VF = 2, VS = 2, VB = 4;
   localparam int OW = 20, ZW = 15;
   localparam int HT = HV + HF + HS + HB;
   localparam int FRAME = HT * (VV + VF + VS + VB);

   logic        clk;
   logic        reset;
   logic        pix_en;
   logic        image_select;
   logic [7:0]  vram_out;
   logic [31:0] gpu_address;
   logic        image_select_out;
   logic        hsync, vsync, de;
   logic [7:0]  pixel;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int pos    = 0;
   logic fs_seen;

   vga_frame_reader #(
      .H_VISIBLE (HV), .V_VISIBLE (VV),
      .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .ORIG_SIZE (OW), .ZOOM_SIZE (ZW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .pix_en           (pix_en),
      .image_select     (image_select),
      .vram_out         (vram_out),
      .gpu_address      (gpu_address),
      .image_select_out (image_select_out),
      .hsync            (hsync),
      .vsync            (vsync),
      .de               (de),
      .pixel            (pixel),
      .frame_start      (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // VRAM returns the low address byte one clk after the address moves.
   always @(posedge clk) begin
      if (reset) vram_out <= 8'd0;
      else vram_out <= gpu_address[7:0];
   end

   task automatic tick();
      @(negedge clk);
      pix_en = 1'b1;
      #1 fs_seen = frame_start;
      @(negedge clk);
      pix_en = 1'b0;
      pos = (pos + 1) % FRAME;
   endtask

   task automatic advance_to(input int target);
      int guard;
      guard = 0;
      while (pos != target && guard < FRAME) begin
         tick();
         guard++;
      end
      checks++;
      if (pos != target) begin
         errors++;
         $display("FAIL advance_to: pos %0d, required %0d", pos, target);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pix_en = 1'b0;
      image_select = 1'b0;
      repeat (2) @(negedge clk);
      pix_en = 1'b1;
      #1;
      checks++;
      if (frame_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_fs: got %b, required 0", frame_start);
      end
      @(negedge clk);
      pix_en = 1'b0;
      checks++;
      if (gpu_address !== 32'd0 || image_select_out !== 1'b0 || hsync !== 1'b1 ||
          vsync !== 1'b1 || de !== 1'b0 || pixel !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: addr %0d sel %b hs %b vs %b de %b px %0d, required 0 0 1 1 0 0",
                  gpu_address, image_select_out, hsync, vsync, de, pixel);
      end
      reset = 1'b0;
      pos = 0;
   endtask

   task automatic test_timing();
      int fs_cnt, hs_first, hs_second, hs_low0, vs_low, vs_first, de_cnt;
      logic prev_hs, fs_first;
      fs_cnt = 0; hs_first = 0; hs_second = 0; hs_low0 = 0;
      vs_low = 0; vs_first = 0; de_cnt = 0; prev_hs = 1'b1; fs_first = 1'b0;
      for (int k = 1; k <= 2 * FRAME; k++) begin
         tick();
         if (k == 1) fs_first = fs_seen;
         if (fs_seen) fs_cnt++;
         if (!hsync && prev_hs) begin
            if (hs_first == 0) hs_first = k;
            else if (hs_second == 0) hs_second = k;
         end
         prev_hs = hsync;
         if (k <= HT && !hsync) hs_low0++;
         if (k <= FRAME) begin
            if (!vsync) begin
               vs_low++;
               if (vs_first == 0) vs_first = k;
            end
            if (de) de_cnt++;
         end
      end
      chk32("fs_first_tick", 32'(fs_first), 32'd1);
      chk32("fs_count", fs_cnt, 2);
      chk32("hsync_first_fall", hs_first, HV + HF + 1);
      chk32("hsync_period", hs_second - hs_first, HT);
      chk32("hsync_width", hs_low0, HS);
      chk32("vsync_first_fall", vs_first, (VV + VF) * HT + 1);
      chk32("vsync_low_ticks", vs_low, VS * HT);
      chk32("de_ticks", de_cnt, HV * VV);
   endtask

   task automatic test_orig_image();
      int bad;
      advance_to(HT);
      chk32("orig_addr_line1", gpu_address, OW);
      tick();
      chk32("orig_px_tick0", pixel, OW);
      chk32("orig_de_tick0", 32'(de), 1);
      advance_to(HT + OW);
      chk32("orig_px_tick_last", pixel, 2 * OW - 1);
      bad = 0;
      for (int h = OW; h < HV; h++) begin
         tick();
         if (pixel !== 8'd0 || de !== 1'b1) bad++;
      end
      chk32("orig_outside_px_zero", bad, 0);
      chk32("orig_addr_hold", gpu_address, 2 * OW - 1);
      advance_to(10 * HT);
      image_select = 1'b1;
      tick();
      chk32("toggle_sel_held", 32'(image_select_out), 0);
      advance_to((OW - 1) * HT + OW - 1);
      chk32("orig_last_addr", gpu_address, OW * OW - 1);
      advance_to(25 * HT + 6);
      chk32("orig_low_lines_px", pixel, 0);
      chk32("orig_low_lines_de", 32'(de), 1);
      advance_to(0);
      chk32("toggle_before_fs", 32'(image_select_out), 0);
      tick();
      chk32("toggle_fs", 32'(fs_seen), 1);
      chk32("toggle_after_fs", 32'(image_select_out), 1);
   endtask

   task automatic test_zoom_image();
      advance_to(HT + 3);
      chk32("zoom_addr_3_1", gpu_address, ZW + 3);
      tick();
      chk32("zoom_px_3_1", pixel, ZW + 3);
      advance_to((ZW - 1) * HT + ZW - 1);
      chk32("zoom_last_addr", gpu_address, ZW * ZW - 1);
      advance_to(ZW * HT);
      chk32("zoom_addr_hold", gpu_address, ZW * ZW - 1);
      advance_to(20 * HT + 6);
      chk32("zoom_low_lines_px", pixel, 0);
      chk32("zoom_low_lines_de", 32'(de), 1);
      image_select = 1'b0;
      advance_to(0);
      tick();
      chk32("zoom_back_sel", 32'(image_select_out), 0);
   endtask

   task automatic test_pix_hold();
      advance_to(3 * HT + 7);
      chk32("hold_addr_pre", gpu_address, 3 * OW + 7);
      chk32("hold_px_pre", pixel, 3 * OW + 6);
      repeat (50) @(negedge clk);
      chk32("hold_addr_frozen", gpu_address, 3 * OW + 7);
      chk32("hold_px_frozen", pixel, 3 * OW + 6);
      chk32("hold_de_frozen", 32'(de), 1);
      tick();
      chk32("hold_addr_resume", gpu_address, 3 * OW + 8);
      chk32("hold_px_resume", pixel, 3 * OW + 7);
   endtask

   task automatic test_reset_mid();
      advance_to(15 * HT + 10);
      chk32("mid_addr", gpu_address, 15 * OW + 10);
      tick();
      chk32("mid_px", pixel, (15 * OW + 10) % 256);
      @(negedge clk);
      reset = 1'b1;
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      reset = 1'b0;
      pos = 0;
      checks++;
      if (gpu_address !== 32'd0 || image_select_out !== 1'b0 || hsync !== 1'b1 ||
          vsync !== 1'b1 || de !== 1'b0 || pixel !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_state: addr %0d sel %b hs %b vs %b de %b px %0d, required 0 0 1 1 0 0",
                  gpu_address, image_select_out, hsync, vsync, de, pixel);
      end
      tick();
      chk32("mid_restart_fs", 32'(fs_seen), 1);
      chk32("mid_restart_addr", gpu_address, 1);
      tick();
      chk32("mid_restart_px", pixel, 1);
      chk32("mid_restart_de", 32'(de), 1);
   endtask

   initial begin
      reset = 1'b1;
      pix_en = 1'b0;
      image_select = 1'b0;
      fs_seen = 1'b0;
      test_reset();
      test_timing();
      test_orig_image();
      test_zoom_image();
      test_pix_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-003 Parameters H_FP=16, H_SYNC=96, H_BP=48, V_FP=10, V_SYNC=2, V_BP=33 SHALL set the porch and sync widths, giving 800 ticks per line and 525 lines per frame.
REQ-004 Parameters ORIG_SIZE=400 and ZOOM_SIZE=300 SHALL set the edge length of the square original and zoomed images.
REQ-005 Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high.
- pix_en  input  1  pixel-tick enable; all timing state advances only when high.
- image_select  input  1  requested image: 0 = original, 1 = zoomed.
- vram_out  input  8  grayscale byte read from CPU VRAM, valid one clk after gpu_address changes.
- gpu_address  output  32  VRAM read address.
- image_select_out  output  1  frame-latched select driven to the CPU VRAM port.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- de  output  1  display enable, high in the visible area.
- pixel  output  8  grayscale pixel.
- frame_start  output  1  one-tick pulse at the first tick of each frame.

Function
REQ-006 Counters h_cnt (0..799) and v_cnt (0..524) SHALL advance only on pix_en; h_cnt wraps 799->0 and increments v_cnt; v_cnt wraps 524->0.
REQ-007 On the pix_en tick where the counters reach (0,0), image_select SHALL be latched into image_select_out and frame_start SHALL be high for exactly that tick; image_select changes mid-frame SHALL have no effect until the next frame.
REQ-008 The active edge length W SHALL be ORIG_SIZE when image_select_out=0 and ZOOM_SIZE when image_select_out=1.
REQ-009 A counter position SHALL be in-image when h_cnt<W and v_cnt<W.
REQ-010 gpu_address SHALL hold the row-major address v_cnt*W+h_cnt of the in-image pixel at the current counter position, computed by a running increment with no multiplier, and SHALL be 0 at frame start.
REQ-011 gpu_address SHALL hold its value across non-image positions, and bits 31:18 SHALL always be 0; the maximum value is 159999.
REQ-012 The outputs hsync, vsync, de and pixel SHALL be registered on pix_en and SHALL lag the counters by exactly one pixel tick.
REQ-013 hsync SHALL be low for h_cnt in 656..751, and vsync SHALL be low for v_cnt in 490..491, both taken from the delayed counter position.
REQ-014 de SHALL be high for delayed positions with h<640 and v<480.
REQ-015 pixel SHALL equal vram_out sampled on the tick for delayed in-image positions, and 0 elsewhere, including visible positions outside the image.
REQ-016 pix_en SHALL have at least 2 clk between assertions, which guarantees vram_out has settled; with pix_en held low, all state and outputs SHALL hold.

Reset
REQ-017 While reset is high on a clk edge, the following SHALL be cleared regardless of pix_en: h_cnt=0, v_cnt=0, gpu_address=0, image_select_out=0, hsync=1, vsync=1, de=0, pixel=0, frame_start=0.
REQ-018 After reset deasserts, the first pix_en tick SHALL be treated as frame start: latch image_select and pulse frame_start.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately, with no partial-line completion.

Structure
REQ-020 The timing parameters, image sizes, and a 2-bit region enum (VISIBLE, FRONT, SYNC, BACK) SHALL live in the shared package vga_pkg.
REQ-021 One sub-module, vga_timing, SHALL own h_cnt/v_cnt, the sync/region decode and frame_start; vga_frame_reader SHALL own address generation, the select latch and the output pipeline.

Verification
REQ-022 Reset, then pix_en every 2nd clk with image_select=0 -> hsync period 800 ticks with a 96-tick low pulse; vsync low for 2 lines of every 525; frame_start once per 420000 ticks.
REQ-023 VRAM model returning addr[7:0] with select 0 -> on line 1, de-qualified pixel tick 0 =144 (400 mod 256), tick 399 =31; ticks 400..639 =0; last in-image gpu_address =159999.
REQ-024 Select 1 -> last in-image gpu_address =89999; lines 300..479 have pixel=0 with de=1.
REQ-025 Toggle image_select at line 200 -> image_select_out and W unchanged until the next frame_start, then switch.
REQ-026 Assert reset at h=500, v=300 -> on the next clk, outputs equal reset values; after release, the frame restarts at (0,0) with gpu_address=0.
REQ-027 Hold pix_en low for 50 clks mid-line -> all outputs and gpu_address are frozen, and resume without a skipped or duplicated pixel.
